// File: rtl/tip_axi_copy_initiator.sv
// AXI copy initiator: one INCR read burst into a local buffer, then one INCR
// write burst of the same length from that buffer to the destination.
module tip_axi_copy_initiator #(
  parameter int BW_ADDR   = 32,
  parameter int BW_DATA   = 32,
  parameter int BW_TID    = 4,
  parameter int TID       = 0,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rstpp,
  input  logic                 start,
  input  logic [BW_ADDR-1:0]   src_addr,
  input  logic [BW_ADDR-1:0]   dst_addr,
  input  logic [8:0]           num_beats,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 sxarvalid,
  input  logic                 sxarready,
  output logic [BW_ADDR-1:0]   sxaraddr,
  output logic [BW_TID-1:0]    sxarid,
  output logic [7:0]           sxarlen,
  output logic [2:0]           sxarsize,
  output logic [1:0]           sxarburst,
  input  logic                 sxrvalid,
  output logic                 sxrready,
  input  logic [BW_TID-1:0]    sxrid,
  input  logic [BW_DATA-1:0]   sxrdata,
  input  logic                 sxrlast,
  input  logic [1:0]           sxrresp,
  output logic                 sxawvalid,
  input  logic                 sxawready,
  output logic [BW_ADDR-1:0]   sxawaddr,
  output logic [BW_TID-1:0]    sxawid,
  output logic [7:0]           sxawlen,
  output logic [2:0]           sxawsize,
  output logic [1:0]           sxawburst,
  output logic                 sxwvalid,
  input  logic                 sxwready,
  output logic [BW_TID-1:0]    sxwid,
  output logic [BW_DATA-1:0]   sxwdata,
  output logic [BW_DATA/8-1:0] sxwstrb,
  output logic                 sxwlast,
  input  logic                 sxbvalid,
  output logic                 sxbready,
  input  logic [BW_TID-1:0]    sxbid,
  input  logic [1:0]           sxbresp
);

  localparam int BPB  = BW_DATA / 8;
  localparam int SIZE = $clog2(BPB);
  localparam int IW   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AW, ST_W, ST_B} state_t;

  state_t              state, state_n;
  logic [BW_ADDR-1:0]  src_q, dst_q, src_al, dst_al;
  logic [8:0]          nb_q, idx, idx_inc;
  logic [7:0]          len_q;
  logic [BW_DATA-1:0]  mem [MAX_BEATS];
  logic [BW_DATA-1:0]  wdata_q;
  logic                wlast_q, busy_q, done_q, error_q, done_d;
  logic                reject, r_fire, r_bad, w_fire;
  logic [12:0]         src_end, dst_end;

  // Responder IDs are deliberately ignored.
  wire unused_ids = ^{sxrid, sxbid};

  assign src_al  = src_addr & ~BW_ADDR'(BPB - 1);
  assign dst_al  = dst_addr & ~BW_ADDR'(BPB - 1);
  assign src_end = 13'(src_al[11:0]) + 13'(num_beats) * 13'(BPB);
  assign dst_end = 13'(dst_al[11:0]) + 13'(num_beats) * 13'(BPB);
  assign reject  = (num_beats == 9'd0) || (num_beats > 9'(MAX_BEATS)) ||
                   (src_end > 13'd4096) || (dst_end > 13'd4096);

  assign r_fire  = sxrvalid && (state == ST_R);
  assign r_bad   = (sxrresp != 2'b00) || (sxrlast && (idx != nb_q - 9'd1));
  assign w_fire  = sxwready && (state == ST_W);
  assign idx_inc = idx + 9'd1;

  always_ff @(posedge clk or posedge rstpp) begin
    if (rstpp) state <= ST_IDLE;
    else       state <= state_n;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    done_d  = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        if (reject) done_d  = 1'b1;
        else        state_n = ST_AR;
      end
      ST_AR: if (sxarready) state_n = ST_R;
      ST_R: if (r_fire && sxrlast) begin
        if (error_q || r_bad) begin
          state_n = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_n = ST_AW;
        end
      end
      ST_AW: if (sxawready) state_n = ST_W;
      ST_W:  if (w_fire && wlast_q) state_n = ST_B;
      ST_B: if (sxbvalid) begin
        state_n = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: the copy buffer has no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    if (r_fire && (idx < nb_q)) mem[idx[IW-1:0]] <= sxrdata;
  end

  always_ff @(posedge clk or posedge rstpp) begin
    if (rstpp) begin
      src_q   <= '0;
      dst_q   <= '0;
      nb_q    <= '0;
      len_q   <= '0;
      idx     <= '0;
      wdata_q <= '0;
      wlast_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      busy_q <= (state_n != ST_IDLE);
      done_q <= done_d;
      case (state)
        ST_IDLE: if (start) begin
          src_q   <= src_al;
          dst_q   <= dst_al;
          nb_q    <= num_beats;
          len_q   <= 8'(num_beats - 9'd1);
          idx     <= '0;
          error_q <= reject;
        end
        ST_R: if (r_fire) begin
          if (r_bad) error_q <= 1'b1;
          if (sxrlast)             idx <= '0;
          else if (idx != 9'h1FF) idx <= idx_inc;
        end
        ST_AW: if (sxawready) begin
          wdata_q <= mem[0];
          wlast_q <= (nb_q == 9'd1);
        end
        ST_W: if (w_fire) begin
          if (wlast_q) begin
            idx     <= '0;
            wlast_q <= 1'b0;
          end else begin
            idx     <= idx_inc;
            wdata_q <= mem[idx_inc[IW-1:0]];
            wlast_q <= (idx_inc == nb_q - 9'd1);
          end
        end
        ST_B: if (sxbvalid && (sxbresp != 2'b00)) error_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

  assign sxarvalid = (state == ST_AR);
  assign sxaraddr  = src_q;
  assign sxarid    = BW_TID'(TID);
  assign sxarlen   = len_q;
  assign sxarsize  = 3'(SIZE);
  assign sxarburst = 2'b01;
  assign sxrready  = (state == ST_R);

  assign sxawvalid = (state == ST_AW);
  assign sxawaddr  = dst_q;
  assign sxawid    = BW_TID'(TID);
  assign sxawlen   = len_q;
  assign sxawsize  = 3'(SIZE);
  assign sxawburst = 2'b01;

  assign sxwvalid  = (state == ST_W);
  assign sxwid     = BW_TID'(TID);
  assign sxwdata   = wdata_q;
  assign sxwstrb   = '1;
  assign sxwlast   = wlast_q;
  assign sxbready  = (state == ST_B);

endmodule
